led_frame_sched: RTL and testbench

LED_FRAME_SCHED -- requirements
Module: led_frame_sched

---
 rtl/led_frame_sched.sv | 183 ++++++++++++++++++
 tb/tb_led_frame_sched.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/led_frame_sched.sv
// LED frame scheduler: refresh timer, trigger merge, pixel RAM to FIFO copy,
// serial sender handshake with acknowledge timeout.
module led_frame_sched #(
  parameter int LED_NUM     = 4,
  parameter int REFRESH_CNT = 150000,
  parameter int ADDR_W      = 8,
  parameter int ACK_TMO     = 64
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              auto_en,
  input  logic              force_req,
  input  logic              clr_err,
  output logic              pix_rd,
  output logic [ADDR_W-1:0] pix_addr,
  input  logic [23:0]       pix_data,
  output logic              fifo_wr,
  output logic [23:0]       fifo_wdata,
  input  logic              fifo_full,
  output logic              tx_start,
  input  logic              tx_busy,
  output logic              busy,
  output logic [15:0]       frame_cnt,
  output logic              err_ovr,
  output logic              err_tmo
);

  localparam int TW = (REFRESH_CNT > 1) ? $clog2(REFRESH_CNT) : 1;
  localparam int KW = $clog2(ACK_TMO + 1);
  localparam logic [TW-1:0]     TMR_LAST = TW'(REFRESH_CNT - 1);
  localparam logic [KW-1:0]     TMO_LAST = KW'(ACK_TMO - 1);
  localparam logic [ADDR_W-1:0] IDX_LAST = ADDR_W'(LED_NUM - 1);

  typedef enum logic [2:0] {
    IDLE,
    FILL,
    START,
    WAIT_ACK,
    WAIT_DONE
  } state_t;

  state_t            state_q, state_d;
  logic [TW-1:0]     tmr;
  logic              tick;
  logic              trig;
  logic              pending;
  logic              pend_clr;
  logic              ovr_set;
  logic [ADDR_W-1:0] idx_q, idx_d;
  logic              wr_q, wr_d;
  logic [KW-1:0]     tmo_q, tmo_d;
  logic              tmo_set;
  logic              done;

  // Timer sits at zero while disabled so the first tick is a full period out.
  assign tick = auto_en && (tmr == TMR_LAST);

  always_ff @(posedge clk) begin
    if (rst) begin
      tmr <= '0;
    end else if (!auto_en || tick) begin
      tmr <= '0;
    end else begin
      tmr <= tmr + 1'b1;
    end
  end

  assign trig     = tick | force_req;
  assign pend_clr = (state_q == IDLE) && pending;
  assign ovr_set  = trig && pending && !pend_clr;

  always_ff @(posedge clk) begin
    if (rst) begin
      pending <= 1'b0;
    end else begin
      pending <= trig | (pending & ~pend_clr);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      idx_q   <= '0;
      wr_q    <= 1'b0;
      tmo_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      wr_q    <= wr_d;
      tmo_q   <= tmo_d;
    end
  end

  // wr_q marks a RAM read issued last cycle; its write is never stalled.
  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    wr_d     = wr_q;
    tmo_d    = tmo_q;
    pix_rd   = 1'b0;
    fifo_wr  = 1'b0;
    tx_start = 1'b0;
    tmo_set  = 1'b0;
    done     = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (pending) begin
          state_d = FILL;
          idx_d   = '0;
          wr_d    = 1'b0;
        end
      end
      FILL: begin
        if (wr_q) begin
          fifo_wr = 1'b1;
          wr_d    = 1'b0;
          idx_d   = idx_q + 1'b1;
          if (idx_q == IDX_LAST) begin
            state_d = START;
            idx_d   = '0;
          end
        end else if (!fifo_full) begin
          pix_rd = 1'b1;
          wr_d   = 1'b1;
        end
      end
      START: begin
        tx_start = 1'b1;
        tmo_d    = KW'(1);
        state_d  = WAIT_ACK;
      end
      WAIT_ACK: begin
        if (tx_busy) begin
          state_d = WAIT_DONE;
        end else if (tmo_q == TMO_LAST) begin
          tmo_set = 1'b1;
          state_d = IDLE;
        end else begin
          tmo_d = tmo_q + 1'b1;
        end
      end
      WAIT_DONE: begin
        if (!tx_busy) begin
          done    = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign pix_addr   = idx_q;
  assign fifo_wdata = fifo_wr ? pix_data : 24'd0;
  assign busy       = (state_q != IDLE);

  always_ff @(posedge clk) begin
    if (rst) begin
      frame_cnt <= '0;
    end else if (done) begin
      frame_cnt <= frame_cnt + 16'd1;
    end
  end

  // Set events take priority over a same-cycle clear.
  always_ff @(posedge clk) begin
    if (rst) begin
      err_ovr <= 1'b0;
      err_tmo <= 1'b0;
    end else begin
      if (ovr_set) begin
        err_ovr <= 1'b1;
      end else if (clr_err) begin
        err_ovr <= 1'b0;
      end
      if (tmo_set) begin
        err_tmo <= 1'b1;
      end else if (clr_err) begin
        err_tmo <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_led_frame_sched.sv
// Directed bench for led_frame_sched with RAM, sender and write-log models.
module tb_led_frame_sched;

  localparam int LN = 4;
  localparam int RC = 100;
  localparam int AW = 8;
  localparam int AT = 64;

  logic          clk = 1'b0;
  logic          rst, auto_en, force_req, clr_err;
  logic          pix_rd, fifo_wr, fifo_full, tx_start, tx_busy;
  logic          busy, err_ovr, err_tmo;
  logic [AW-1:0] pix_addr;
  logic [23:0]   pix_data = 24'd0;
  logic [23:0]   fifo_wdata;
  logic [15:0]   frame_cnt;

  led_frame_sched #(
    .LED_NUM(LN), .REFRESH_CNT(RC), .ADDR_W(AW), .ACK_TMO(AT)
  ) dut (
    .clk(clk), .rst(rst), .auto_en(auto_en), .force_req(force_req),
    .clr_err(clr_err), .pix_rd(pix_rd), .pix_addr(pix_addr),
    .pix_data(pix_data), .fifo_wr(fifo_wr), .fifo_wdata(fifo_wdata),
    .fifo_full(fifo_full), .tx_start(tx_start), .tx_busy(tx_busy),
    .busy(busy), .frame_cnt(frame_cnt), .err_ovr(err_ovr),
    .err_tmo(err_tmo)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk) begin
    if (pix_rd) pix_data <= 24'hA0 + 24'(pix_addr);
  end

  int snd_cnt = 0;
  bit snd_en;
  int snd_len;
  always @(posedge clk) begin
    if (rst) snd_cnt <= 0;
    else if (tx_start && snd_en) snd_cnt <= snd_len;
    else if (snd_cnt > 0) snd_cnt <= snd_cnt - 1;
  end
  assign tx_busy = (snd_cnt != 0);

  logic [23:0] wr_q[$];
  int wr_t[$];
  int tx_t[$];
  int rd_n = 0;
  int both_n = 0;
  int gap_n = 0;
  always @(posedge clk) begin
    if (fifo_wr) begin
      wr_q.push_back(fifo_wdata);
      wr_t.push_back(cyc);
    end
    if (tx_start) tx_t.push_back(cyc);
    if (pix_rd) rd_n++;
    if (pix_rd && fifo_wr) both_n++;
    if ((pix_rd || fifo_wr || tx_start) && !busy) gap_n++;
  end

  int nchk = 0;
  int npass = 0;

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    nchk++;
    assert (obs === exp) npass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic step(int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic pulse_force();
    force_req = 1'b1;
    step(1);
    force_req = 1'b0;
  endtask

  task automatic clear_logs();
    wr_q.delete();
    wr_t.delete();
    tx_t.delete();
  endtask

  task automatic wait_tx(int lim);
    int k;
    k = 0;
    while (tx_t.size() == 0 && k < lim) begin
      step(1);
      k++;
    end
  endtask

  task automatic wait_frames(int tgt, int lim, string tag);
    int k;
    k = 0;
    while (frame_cnt != 16'(tgt) && k < lim) begin
      step(1);
      k++;
    end
    chk(tag, 32'(frame_cnt), 32'(tgt));
  endtask

  task automatic chk_pixels(string tag);
    chk({tag, "_nwr"}, 32'(wr_q.size()), 32'(LN));
    for (int i = 0; i < LN; i++) begin
      chk($sformatf("%s_px%0d", tag, i), 32'(wr_q[i]), 32'hA0 + 32'(i));
    end
  endtask

  int c0, f0, rd0, k;

  initial begin
    rst = 1'b1; auto_en = 1'b0; force_req = 1'b0; clr_err = 1'b0;
    fifo_full = 1'b0; snd_en = 1'b1; snd_len = 20;
    step(3);
    chk("rst_flags",
        32'({pix_rd, fifo_wr, tx_start, busy, err_ovr, err_tmo}), 32'd0);
    chk("rst_addr", 32'(pix_addr), 32'd0);
    chk("rst_wdata", 32'(fifo_wdata), 32'd0);
    chk("rst_fcnt", 32'(frame_cnt), 32'd0);
    rst = 1'b0;
    step(2);

    // Single forced frame, no backpressure
    clear_logs();
    pulse_force();
    step(1);
    chk("t1_busy", 32'(busy), 32'd1);
    wait_tx(50);
    chk_pixels("t1");
    for (int i = 1; i < LN; i++) begin
      chk($sformatf("t1_gap%0d", i), 32'(wr_t[i] - wr_t[i-1]), 32'd2);
    end
    chk("t1_tx_lat", 32'(tx_t[0] - wr_t[LN-1]), 32'd1);
    wait_frames(1, 100, "t1_fcnt");
    chk("t1_ovr", 32'(err_ovr), 32'd0);
    step(2);

    // FIFO full stall after pixel 1 read
    clear_logs();
    pulse_force();
    k = 0;
    while (!(pix_rd && pix_addr == 8'd1) && k < 50) begin
      step(1);
      k++;
    end
    chk("t2_rd1", 32'({pix_rd, pix_addr}), 32'h101);
    step(1);
    fifo_full = 1'b1;
    chk("t2_wr1", 32'(fifo_wr), 32'd1);
    chk("t2_wd1", 32'(fifo_wdata), 32'hA1);
    rd0 = rd_n;
    step(10);
    chk("t2_stall_rd", 32'(rd_n - rd0), 32'd0);
    chk("t2_stall_tx", 32'(tx_t.size()), 32'd0);
    fifo_full = 1'b0;
    wait_tx(50);
    chk_pixels("t2");
    wait_frames(2, 100, "t2_fcnt");
    step(2);

    // Merged triggers during a long frame
    snd_len = 50;
    clear_logs();
    pulse_force();
    step(20);
    pulse_force();
    chk("t3_ovr_first", 32'(err_ovr), 32'd0);
    pulse_force();
    chk("t3_ovr_set", 32'(err_ovr), 32'd1);
    force_req = 1'b1;
    clr_err = 1'b1;
    step(1);
    force_req = 1'b0;
    clr_err = 1'b0;
    chk("t3_set_wins", 32'(err_ovr), 32'd1);
    clr_err = 1'b1;
    step(1);
    clr_err = 1'b0;
    chk("t3_ovr_clr", 32'(err_ovr), 32'd0);
    wait_frames(4, 300, "t3_fcnt");
    chk("t3_ovr_end", 32'(err_ovr), 32'd0);
    step(2);
    snd_len = 20;

    // Auto refresh for three periods
    clear_logs();
    c0 = cyc;
    auto_en = 1'b1;
    step(340);
    auto_en = 1'b0;
    chk("t4_ntx", 32'(tx_t.size()), 32'd3);
    chk("t4_first", 32'(tx_t[0] - c0), 32'd109);
    chk("t4_per1", 32'(tx_t[1] - tx_t[0]), 32'(RC));
    chk("t4_per2", 32'(tx_t[2] - tx_t[1]), 32'(RC));
    step(5);
    chk("t4_fcnt", 32'(frame_cnt), 32'd7);
    chk("t4_ovr", 32'(err_ovr), 32'd0);

    // Sender never acknowledges
    snd_en = 1'b0;
    clear_logs();
    f0 = cyc;
    pulse_force();
    k = 0;
    while (!err_tmo && k < 150) begin
      step(1);
      k++;
    end
    chk("t5_ntx", 32'(tx_t.size()), 32'd1);
    chk("t5_tmo_lat", 32'(cyc - tx_t[0]), 32'(AT));
    chk("t5_tx_at", 32'(tx_t[0] - f0), 32'd10);
    chk("t5_idle", 32'(busy), 32'd0);
    chk("t5_fcnt", 32'(frame_cnt), 32'd7);
    clr_err = 1'b1;
    step(1);
    clr_err = 1'b0;
    chk("t5_tmo_clr", 32'(err_tmo), 32'd0);
    snd_en = 1'b1;
    step(2);

    // Reset in the middle of a fill
    clear_logs();
    pulse_force();
    k = 0;
    while (wr_q.size() < 2 && k < 50) begin
      step(1);
      k++;
    end
    chk("t6_nwr", 32'(wr_q.size()), 32'd2);
    rst = 1'b1;
    step(1);
    chk("t6_flags",
        32'({pix_rd, fifo_wr, tx_start, busy, err_ovr, err_tmo}), 32'd0);
    chk("t6_addr", 32'(pix_addr), 32'd0);
    chk("t6_wdata", 32'(fifo_wdata), 32'd0);
    chk("t6_fcnt", 32'(frame_cnt), 32'd0);
    rd0 = rd_n;
    tx_t.delete();
    rst = 1'b0;
    step(30);
    chk("t6_no_rd", 32'(rd_n - rd0), 32'd0);
    chk("t6_no_tx", 32'(tx_t.size()), 32'd0);
    chk("t6_no_wr", 32'(wr_q.size()), 32'd2);
    chk("t6_idle", 32'(busy), 32'd0);

    chk("rd_wr_overlap", 32'(both_n), 32'd0);
    chk("strobe_idle", 32'(gap_n), 32'd0);

    $display("%0d/%0d checks passed", npass, nchk);
    $finish;
  end

endmodule
